// File: rtl/tms34020_scrref_xfer_pkg.sv
// Shared definitions for the screen-refresh transfer path: FSM states,
// default timeout and the DPYTAP/DPYMSK address merge.
package tms34020_scrref_xfer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    XFER,
    WAIT,
    DONE
  } ScrXferState_t;

  localparam int unsigned SCRXFER_TMO_DEF = 255;

  // Masked bits come from the tap point, the rest from the refresh address.
  function automatic logic [15:0] tap_merge(input logic [15:0] addr_lo,
                                            input logic [15:0] tap,
                                            input logic [15:0] msk);
    return (addr_lo & ~msk) | (tap & msk);
  endfunction

endpackage

// File: rtl/tms34020_scrref_xfer_if.sv
// Local memory bus seen by the refresh transfer engine: arbitration plus
// the address/strobe/ready handshake of the read-transfer cycle.
interface tms34020_scrref_xfer_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              BUS_REQ;
  logic              BUS_GNT;
  logic [ADDR_W-1:0] MEM_A;
  logic              MEM_TR;
  logic              MEM_STB;
  logic              MEM_RDY;

  modport master (
    output BUS_REQ, MEM_A, MEM_TR, MEM_STB,
    input  BUS_GNT, MEM_RDY
  );

  modport slave (
    input  BUS_REQ, MEM_A, MEM_TR, MEM_STB,
    output BUS_GNT, MEM_RDY
  );
endinterface

// File: rtl/tms34020_scrref_xfer.sv
// Consumes the per-line screen-refresh request and runs one VRAM
// read-transfer cycle on the local bus, flagging overruns and timeouts.
module tms34020_scrref_xfer
  import tms34020_scrref_xfer_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TMO_CYC = SCRXFER_TMO_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  EN,
  input  logic                  CE_R,
  input  logic                  SCRREF_RUN,
  input  logic [ADDR_W-1:0]     SCRREF_ADDR,
  input  logic [15:0]           DPYTAP,
  input  logic [15:0]           DPYMSK,
  tms34020_scrref_xfer_if.master mem,
  output logic                  XFER_DONE,
  output logic                  OVR_ERR,
  output logic                  TMO_ERR,
  input  logic                  ERR_CLR
);

  localparam logic [7:0] TMO_LIM = TMO_CYC[7:0];

  ScrXferState_t     state_q, state_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] xa_q, xa_d;
  logic [ADDR_W-1:0] mem_a_q, mem_a_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              ok_q, ok_d;
  logic              ovr_q, ovr_d;
  logic              tmo_q, tmo_d;

  logic              step;
  logic              grab;
  logic              ovr_set;
  logic              tmo_set;
  logic [7:0]        cnt_inc;
  logic [ADDR_W-1:0] xa_new;

  assign step    = EN & CE_R;
  assign grab    = (state_q == REQ) & mem.BUS_GNT;
  assign cnt_inc = cnt_q + 8'd1;
  assign xa_new  = {SCRREF_ADDR[ADDR_W-1:16],
                    tap_merge(SCRREF_ADDR[15:0], DPYTAP, DPYMSK)};

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    xa_d    = xa_q;
    mem_a_d = mem_a_q;
    cnt_d   = cnt_q;
    ok_d    = ok_q;
    ovr_d   = ovr_q;
    tmo_d   = tmo_q;
    ovr_set = 1'b0;
    tmo_set = 1'b0;

    if (step) begin
      unique case (state_q)
        IDLE: if (pend_q || SCRREF_RUN) state_d = REQ;
        REQ: begin
          if (mem.BUS_GNT) begin
            state_d = XFER;
            // A request arriving on the grant step is the newest address.
            mem_a_d = SCRREF_RUN ? xa_new : xa_q;
            pend_d  = 1'b0;
            cnt_d   = '0;
          end
        end
        XFER: state_d = WAIT;
        WAIT: begin
          cnt_d = cnt_inc;
          if (mem.MEM_RDY) begin
            state_d = DONE;
            ok_d    = 1'b1;
          end else if (cnt_inc == TMO_LIM) begin
            state_d = DONE;
            ok_d    = 1'b0;
            tmo_set = 1'b1;
          end
        end
        DONE: state_d = (pend_q || SCRREF_RUN) ? REQ : IDLE;
        default: state_d = IDLE;
      endcase

      if (SCRREF_RUN) begin
        ovr_set = pend_q || (state_q == XFER) || (state_q == WAIT);
        if (!grab) begin
          xa_d   = xa_new;
          pend_d = 1'b1;
        end
      end

      if (ERR_CLR) begin
        ovr_d = 1'b0;
        tmo_d = 1'b0;
      end
      if (ovr_set) ovr_d = 1'b1;
      if (tmo_set) tmo_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      pend_q  <= 1'b0;
      xa_q    <= '0;
      mem_a_q <= '0;
      cnt_q   <= '0;
      ok_q    <= 1'b0;
      ovr_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      xa_q    <= xa_d;
      mem_a_q <= mem_a_d;
      cnt_q   <= cnt_d;
      ok_q    <= ok_d;
      ovr_q   <= ovr_d;
      tmo_q   <= tmo_d;
    end
  end

  assign mem.BUS_REQ = (state_q == REQ) || (state_q == XFER) || (state_q == WAIT);
  assign mem.MEM_TR  = (state_q == XFER) || (state_q == WAIT);
  assign mem.MEM_STB = (state_q == XFER) || (state_q == WAIT);
  assign mem.MEM_A   = mem_a_q;
  assign XFER_DONE   = (state_q == DONE) && ok_q;
  assign OVR_ERR     = ovr_q;
  assign TMO_ERR     = tmo_q;

endmodule

// File: tb/tb_tms34020_scrref_xfer.sv
// Bench for tms34020_scrref_xfer: directed scenarios plus random traffic,
// every step compared against a transaction-level reference model.
module tb_tms34020_scrref_xfer;

  localparam int unsigned TMO = 4;

  logic        CLK = 1'b0;
  logic        RST, EN, CE_R, SCRREF_RUN, ERR_CLR;
  logic [31:0] SCRREF_ADDR;
  logic [15:0] DPYTAP, DPYMSK;
  logic        XFER_DONE, OVR_ERR, TMO_ERR;

  tms34020_scrref_xfer_if #(.ADDR_W(32)) mem_if ();

  tms34020_scrref_xfer #(.ADDR_W(32), .TMO_CYC(TMO)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .CE_R(CE_R),
    .SCRREF_RUN(SCRREF_RUN), .SCRREF_ADDR(SCRREF_ADDR),
    .DPYTAP(DPYTAP), .DPYMSK(DPYMSK), .mem(mem_if),
    .XFER_DONE(XFER_DONE), .OVR_ERR(OVR_ERR), .TMO_ERR(TMO_ERR),
    .ERR_CLR(ERR_CLR)
  );

  always #5 CLK = ~CLK;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, act, exp);
  endtask

  // Reference model: a one-deep replaceable pending slot, a "wants bus" flag,
  // the age of the running transfer in steps since grant, and a finish code.
  logic [31:0] m_pend[$];
  bit          m_req  = 0;
  int          m_age  = -1;  // -1 none, 0 address step, k>=1 k-th ready wait
  int          m_fin  = 0;   // 0 none, 1 finished ok, 2 finished by timeout
  bit          m_ovr  = 0;
  bit          m_tmo  = 0;
  logic [31:0] m_addr = '0;

  function automatic logic [31:0] merged(input logic [31:0] a, input logic [15:0] t,
                                         input logic [15:0] m);
    logic [31:0] r;
    r = a;
    for (int i = 0; i < 16; i++) if (m[i]) r[i] = t[i];
    return r;
  endfunction

  task automatic step_clk();
    bit run, ovr_set, tmo_set, busy;
    logic [31:0] nxa;
    @(posedge CLK);
    if (RST) begin
      m_pend.delete();
      m_req = 0; m_age = -1; m_fin = 0; m_ovr = 0; m_tmo = 0; m_addr = '0;
    end else if (EN && CE_R) begin
      run     = SCRREF_RUN;
      nxa     = merged(SCRREF_ADDR, DPYTAP, DPYMSK);
      busy    = (m_pend.size() != 0) || (m_age >= 0);
      ovr_set = run && busy;
      tmo_set = 0;
      if (m_fin != 0) begin
        m_fin = 0;
        m_req = (m_pend.size() != 0) || run;
        if (run) begin m_pend.delete(); m_pend.push_back(nxa); end
      end else if (m_req) begin
        if (mem_if.BUS_GNT) begin
          m_req  = 0;
          m_age  = 0;
          m_addr = run ? nxa : m_pend[0];
          m_pend.delete();
        end else if (run) begin
          m_pend.delete(); m_pend.push_back(nxa);
        end
      end else if (m_age >= 0) begin
        if (m_age == 0) m_age = 1;
        else if (mem_if.MEM_RDY) begin m_age = -1; m_fin = 1; end
        else if (m_age == int'(TMO)) begin m_age = -1; m_fin = 2; tmo_set = 1; end
        else m_age++;
        if (run) begin m_pend.delete(); m_pend.push_back(nxa); end
      end else begin
        m_req = (m_pend.size() != 0) || run;
        if (run) begin m_pend.delete(); m_pend.push_back(nxa); end
      end
      if (ERR_CLR) begin m_ovr = 0; m_tmo = 0; end
      if (ovr_set) m_ovr = 1;
      if (tmo_set) m_tmo = 1;
    end
    #1;
    chk("bus_req",   mem_if.BUS_REQ, 32'(m_req || m_age >= 0));
    chk("mem_stb",   mem_if.MEM_STB, 32'(m_age >= 0));
    chk("mem_tr",    mem_if.MEM_TR,  32'(m_age >= 0));
    chk("mem_a",     mem_if.MEM_A,   m_addr);
    chk("xfer_done", XFER_DONE,      32'(m_fin == 1));
    chk("ovr_err",   OVR_ERR,        32'(m_ovr));
    chk("tmo_err",   TMO_ERR,        32'(m_tmo));
  endtask

  task automatic pulse_run(input logic [31:0] a);
    SCRREF_RUN = 1'b1; SCRREF_ADDR = a;
    step_clk();
    SCRREF_RUN = 1'b0;
  endtask

  int lat, stb_n, done_at;
  bit done_seen;

  initial begin
    RST = 1; EN = 1; CE_R = 1; SCRREF_RUN = 0; ERR_CLR = 0;
    SCRREF_ADDR = '0; DPYTAP = '0; DPYMSK = '0;
    mem_if.BUS_GNT = 0; mem_if.MEM_RDY = 0;
    repeat (2) step_clk();
    RST = 0;
    step_clk();

    // Basic transfer, grant already high.
    DPYMSK = 16'h00FF; DPYTAP = 16'h0012; mem_if.BUS_GNT = 1; mem_if.MEM_RDY = 1;
    pulse_run(32'h0003_4567);
    lat = 1; stb_n = 0; done_at = 0;
    for (int i = 0; i < 8; i++) begin
      step_clk(); lat++;
      if (mem_if.MEM_STB) begin
        stb_n++;
        chk("basic_addr", mem_if.MEM_A, 32'h0003_4512);
      end
      if (XFER_DONE && done_at == 0) done_at = lat;
    end
    chk("basic_stb_steps", stb_n, 2);
    chk("basic_done_lat", done_at, 4);

    // Grant held off for ten steps.
    mem_if.BUS_GNT = 0; mem_if.MEM_RDY = 0;
    pulse_run(32'h0000_1000);
    for (int i = 0; i < 10; i++) begin
      step_clk();
      chk("gnt_req_held", mem_if.BUS_REQ, 1);
      chk("gnt_no_stb", mem_if.MEM_STB, 0);
    end
    mem_if.BUS_GNT = 1; mem_if.MEM_RDY = 1; done_seen = 0;
    for (int i = 0; i < 6; i++) begin step_clk(); if (XFER_DONE) done_seen = 1; end
    chk("gnt_done", done_seen, 1);

    // Overrun while waiting for grant, then a request during WAIT.
    DPYMSK = '0; mem_if.BUS_GNT = 0; mem_if.MEM_RDY = 0;
    pulse_run(32'h100);
    pulse_run(32'h200);
    repeat (2) step_clk();
    chk("ovr_flag", OVR_ERR, 1);
    mem_if.BUS_GNT = 1;
    step_clk();
    chk("ovr_addr", mem_if.MEM_A, 32'h200);
    step_clk();
    pulse_run(32'h300);
    mem_if.MEM_RDY = 1;
    step_clk();
    chk("ovr_done1", XFER_DONE, 1);
    step_clk();
    chk("ovr_req2", mem_if.BUS_REQ, 1);
    step_clk();
    chk("ovr_addr2", mem_if.MEM_A, 32'h300);
    repeat (3) step_clk();

    // Timeout with no ready, then clear.
    ERR_CLR = 1; step_clk(); ERR_CLR = 0;
    mem_if.MEM_RDY = 0; done_seen = 0;
    pulse_run(32'h0000_4444);
    for (int i = 0; i < 8; i++) begin step_clk(); if (XFER_DONE) done_seen = 1; end
    chk("tmo_flag", TMO_ERR, 1);
    chk("tmo_no_done", done_seen, 0);
    chk("tmo_bus_free", mem_if.BUS_REQ, 0);
    ERR_CLR = 1; step_clk(); ERR_CLR = 0;
    chk("clr_tmo", TMO_ERR, 0);
    chk("clr_ovr", OVR_ERR, 0);

    // Ready arriving on the final permitted wait step is a success.
    done_seen = 0;
    pulse_run(32'h0000_5555);
    for (int i = 1; i <= 8; i++) begin
      mem_if.MEM_RDY = (i == 6);
      step_clk();
      if (XFER_DONE) done_seen = 1;
    end
    chk("edge_rdy_done", done_seen, 1);
    chk("edge_rdy_tmo", TMO_ERR, 0);

    // Reset in the middle of WAIT with a request pending.
    mem_if.MEM_RDY = 0;
    pulse_run(32'h0000_6000);
    repeat (2) step_clk();
    pulse_run(32'h0000_7000);
    RST = 1; step_clk(); RST = 0;
    chk("rst_req", mem_if.BUS_REQ, 0);
    chk("rst_stb", mem_if.MEM_STB, 0);
    repeat (3) begin step_clk(); chk("rst_pend_gone", mem_if.BUS_REQ, 0); end
    mem_if.MEM_RDY = 1; done_seen = 0;
    pulse_run(32'h0000_8000);
    for (int i = 0; i < 6; i++) begin step_clk(); if (XFER_DONE) done_seen = 1; end
    chk("rst_recover", done_seen, 1);

    // Enable gating during WAIT; requests while gated are ignored.
    mem_if.MEM_RDY = 0;
    pulse_run(32'h0000_9000);
    repeat (3) step_clk();
    EN = 0; SCRREF_RUN = 1;
    repeat (5) step_clk();
    EN = 1; CE_R = 0;
    repeat (5) step_clk();
    CE_R = 1; SCRREF_RUN = 0;
    repeat (6) step_clk();
    chk("gate_no_ovr", OVR_ERR, 0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      RST            = ($urandom_range(0, 299) == 0);
      EN             = ($urandom_range(0, 7) != 0);
      CE_R           = ($urandom_range(0, 3) != 0);
      SCRREF_RUN     = ($urandom_range(0, 9) == 0);
      SCRREF_ADDR    = $urandom;
      DPYTAP         = 16'($urandom);
      DPYMSK         = 16'($urandom);
      mem_if.BUS_GNT = ($urandom_range(0, 2) != 0);
      mem_if.MEM_RDY = ($urandom_range(0, 4) == 0);
      ERR_CLR        = ($urandom_range(0, 39) == 0);
      step_clk();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
